// File: rtl/ulpi_reg_sequencer.sv
// ulpi_reg_sequencer
//   Owns the ULPI PHY register-access port. After READY rises it writes
//   FUNC_CTRL and OTG_CTRL, reads both back and verifies them, retrying
//   failed, timed-out or mismatched accesses. Once configured it forwards
//   single register accesses from one user requester, one at a time.
//
// Ports
//   CLK_60M, NRST_A_USB          : ULPI clock, async active-low reset
//   READY                        : ULPI link ready (low = PHY unusable)
//   REG_EN/RW/ADDR/DATA_I        : access strobe and fields to the ULPI core
//   REG_DATA_O/REG_DONE/REG_FAIL : access result from the ULPI core
//   USR_REQ/RW/ADDR/WDATA        : user request (level, held until USR_ACK)
//   USR_ACK/USR_ERR/USR_RDATA    : user completion pulse, error, read data
//   CFG_DONE/CFG_ERR/CFG_STEP    : configuration status
//   DBG_STATE                    : current FSM state, for observation only
//
// Handshake: REG_EN is a one-cycle strobe; REG_RW/ADDR/DATA_I are valid on the
// strobe cycle and stay stable until REG_DONE or REG_FAIL. USR_REQ is a level
// that the requester holds until the one-cycle USR_ACK; USR_ERR and USR_RDATA
// are meaningful on the USR_ACK cycle.
module ulpi_reg_sequencer #(
  parameter logic [5:0]  FUNC_CTRL_ADDR = 6'h04,
  parameter logic [5:0]  OTG_CTRL_ADDR  = 6'h0A,
  parameter logic [7:0]  FUNC_CTRL_VAL  = 8'h41,
  parameter logic [7:0]  OTG_CTRL_VAL   = 8'h06,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  input  logic       READY,
  output logic       REG_EN,
  output logic       REG_RW,
  output logic [5:0] REG_ADDR,
  output logic [7:0] REG_DATA_I,
  input  logic [7:0] REG_DATA_O,
  input  logic       REG_DONE,
  input  logic       REG_FAIL,
  input  logic       USR_REQ,
  input  logic       USR_RW,
  input  logic [5:0] USR_ADDR,
  input  logic [7:0] USR_WDATA,
  output logic       USR_ACK,
  output logic       USR_ERR,
  output logic [7:0] USR_RDATA,
  output logic       CFG_DONE,
  output logic       CFG_ERR,
  output logic [1:0] CFG_STEP,
  output logic [3:0] DBG_STATE
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_WAIT_READY, S_ISSUE, S_WAIT, S_CHECK, S_RETRY,
    S_CONFIGURED, S_UISSUE, S_UWAIT, S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    step_q, step_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rewrite_q, rewrite_d;  // current write step is a re-write after a bad read-back
  logic          match_q, match_d;      // read-back result, captured with REG_DONE
  logic          reg_en_q, reg_en_d;
  logic          reg_rw_q, reg_rw_d;
  logic [5:0]    reg_addr_q, reg_addr_d;
  logic [7:0]    reg_wdata_q, reg_wdata_d;
  logic          usr_ack_q, usr_ack_d;
  logic          usr_err_q, usr_err_d;
  logic [7:0]    usr_rdata_q, usr_rdata_d;
  logic          cfg_done_q, cfg_done_d;
  logic          cfg_err_q, cfg_err_d;
  logic [7:0]    exp_val;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    rewrite_d   = rewrite_q;
    match_d     = match_q;
    reg_en_d    = 1'b0;
    reg_rw_d    = reg_rw_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    usr_ack_d   = 1'b0;
    usr_err_d   = 1'b0;
    usr_rdata_d = usr_rdata_q;
    cfg_done_d  = cfg_done_q;
    cfg_err_d   = cfg_err_q;
    exp_val     = step_q[0] ? OTG_CTRL_VAL : FUNC_CTRL_VAL;

    if (!READY) begin
      state_d    = S_WAIT_READY;
      step_d     = '0;
      retry_d    = '0;
      timer_d    = '0;
      rewrite_d  = 1'b0;
      cfg_done_d = 1'b0;
      cfg_err_d  = 1'b0;
      if (state_q == S_UISSUE || state_q == S_UWAIT) begin
        usr_ack_d = 1'b1;
        usr_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_WAIT_READY: state_d = S_ISSUE;
        S_ISSUE: begin
          timer_d = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (REG_DONE) begin
            match_d = (REG_DATA_O == exp_val);
            state_d = S_CHECK;
          end else if (REG_FAIL || timer_q == TIMER_MAX) begin
            state_d = S_RETRY;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_CHECK: begin
          if (!step_q[1]) begin
            // A re-write goes straight back to the read that failed and
            // keeps the retry count, so a persistent mismatch exhausts it.
            if (rewrite_q) begin
              step_d    = step_q + 2'd2;
              rewrite_d = 1'b0;
            end else begin
              step_d  = step_q + 2'd1;
              retry_d = '0;
            end
            state_d = S_ISSUE;
          end else if (match_q) begin
            retry_d = '0;
            if (step_q == 2'd3) begin
              state_d    = S_CONFIGURED;
              cfg_done_d = 1'b1;
            end else begin
              step_d  = step_q + 2'd1;
              state_d = S_ISSUE;
            end
          end else begin
            step_d    = step_q - 2'd2;
            rewrite_d = 1'b1;
            state_d   = S_RETRY;
          end
        end
        S_RETRY: begin
          if (retry_q == RETRY_MAX) begin
            state_d   = S_ERROR;
            cfg_err_d = 1'b1;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = S_ISSUE;
          end
        end
        // USR_REQ is still high on the USR_ACK cycle; ack_q blocks a re-issue.
        S_CONFIGURED: if (USR_REQ && !usr_ack_q) state_d = S_UISSUE;
        S_UISSUE: begin
          timer_d = '0;
          state_d = S_UWAIT;
        end
        S_UWAIT: begin
          if (REG_DONE) begin
            usr_ack_d = 1'b1;
            if (!reg_rw_q) usr_rdata_d = REG_DATA_O;
            state_d = S_CONFIGURED;
          end else if (REG_FAIL || timer_q == TIMER_MAX) begin
            usr_ack_d = 1'b1;
            usr_err_d = 1'b1;
            state_d   = S_CONFIGURED;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_ERROR: begin
          if (USR_REQ && !usr_ack_q) begin
            usr_ack_d = 1'b1;
            usr_err_d = 1'b1;
          end
        end
        default: state_d = S_WAIT_READY;
      endcase
    end

    // Fields are loaded only on entry to an issue state and then held.
    if (state_d == S_ISSUE) begin
      reg_en_d    = 1'b1;
      reg_rw_d    = ~step_d[1];
      reg_addr_d  = step_d[0] ? OTG_CTRL_ADDR : FUNC_CTRL_ADDR;
      reg_wdata_d = step_d[0] ? OTG_CTRL_VAL : FUNC_CTRL_VAL;
    end else if (state_d == S_UISSUE) begin
      reg_en_d    = 1'b1;
      reg_rw_d    = USR_RW;
      reg_addr_d  = USR_ADDR;
      reg_wdata_d = USR_WDATA;
    end
  end

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state_q     <= S_WAIT_READY;
      step_q      <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      rewrite_q   <= 1'b0;
      match_q     <= 1'b0;
      reg_en_q    <= 1'b0;
      reg_rw_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      usr_ack_q   <= 1'b0;
      usr_err_q   <= 1'b0;
      usr_rdata_q <= '0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      rewrite_q   <= rewrite_d;
      match_q     <= match_d;
      reg_en_q    <= reg_en_d;
      reg_rw_q    <= reg_rw_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      usr_ack_q   <= usr_ack_d;
      usr_err_q   <= usr_err_d;
      usr_rdata_q <= usr_rdata_d;
      cfg_done_q  <= cfg_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign REG_EN     = reg_en_q;
  assign REG_RW     = reg_rw_q;
  assign REG_ADDR   = reg_addr_q;
  assign REG_DATA_I = reg_wdata_q;
  assign USR_ACK    = usr_ack_q;
  assign USR_ERR    = usr_err_q;
  assign USR_RDATA  = usr_rdata_q;
  assign CFG_DONE   = cfg_done_q;
  assign CFG_ERR    = cfg_err_q;
  assign CFG_STEP   = step_q;
  assign DBG_STATE  = state_q;

endmodule
